// File: rtl/sgbm_delay_pipe.sv
// Runtime-configurable, stallable delay line that keeps a wide data word aligned
// with its row/col sideband and valid flag; the tap stage follows the active depth.
module sgbm_delay_pipe #(
  parameter int unsigned DATA_WIDTH    = 864,
  parameter int unsigned DIM_WIDTH     = 10,
  parameter int unsigned MAX_DEPTH     = 16,
  parameter int unsigned DEPTH_W       = 5,
  parameter int unsigned DEFAULT_DEPTH = 13,
  parameter int unsigned FILL_ONES     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  cfg_wr,
  input  logic [DEPTH_W-1:0]    cfg_depth,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DIM_WIDTH-1:0]  row_in,
  input  logic [DIM_WIDTH-1:0]  col_in,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DIM_WIDTH-1:0]  row_out,
  output logic [DIM_WIDTH-1:0]  col_out,
  output logic                  valid,
  output logic [DEPTH_W-1:0]    depth_cur,
  output logic [DEPTH_W-1:0]    occ
);

  localparam int unsigned IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] FILL = (FILL_ONES != 0) ? '1 : '0;

  logic [DATA_WIDTH-1:0] data_q [MAX_DEPTH];
  logic [DIM_WIDTH-1:0]  row_q  [MAX_DEPTH];
  logic [DIM_WIDTH-1:0]  col_q  [MAX_DEPTH];
  logic [MAX_DEPTH-1:0]  vld_q;
  logic [DEPTH_W-1:0]    depth_q;
  logic [DEPTH_W-1:0]    occ_q;
  logic [DEPTH_W-1:0]    depth_req;
  logic [IDX_W-1:0]      tap;

  // Clamp requested depth into 1..MAX_DEPTH.
  always_comb begin
    depth_req = cfg_depth;
    if (cfg_depth == '0) begin
      depth_req = DEPTH_W'(1);
    end else if (cfg_depth > DEPTH_W'(MAX_DEPTH)) begin
      depth_req = DEPTH_W'(MAX_DEPTH);
    end
  end

  assign tap       = IDX_W'(depth_q - DEPTH_W'(1));
  assign data_out  = data_q[tap];
  assign row_out   = row_q[tap];
  assign col_out   = col_q[tap];
  assign valid     = vld_q[tap];
  assign depth_cur = depth_q;
  assign occ       = occ_q;

  // Payload stages: shift on every non-stalled edge; flush/cfg only touch valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        data_q[i] <= FILL;
        row_q[i]  <= '0;
        col_q[i]  <= '0;
      end
    end else if (!stall) begin
      data_q[0] <= data_in;
      row_q[0]  <= row_in;
      col_q[0]  <= col_in;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        row_q[i]  <= row_q[i-1];
        col_q[i]  <= col_q[i-1];
      end
    end
  end

  // Valid bits, occupancy and active depth; cfg_wr implies a flush and ignores stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      occ_q   <= '0;
      depth_q <= DEPTH_W'(DEFAULT_DEPTH);
    end else if (cfg_wr) begin
      vld_q   <= '0;
      occ_q   <= '0;
      depth_q <= depth_req;
    end else if (flush) begin
      vld_q <= '0;
      occ_q <= '0;
    end else if (!stall) begin
      vld_q <= {vld_q[MAX_DEPTH-2:0], en};
      occ_q <= occ_q + DEPTH_W'(en) - DEPTH_W'(valid);
    end
  end

endmodule

// File: tb/tb_sgbm_delay_pipe.sv
// Directed self-checking bench for sgbm_delay_pipe: reset, latency, stall, flush,
// depth configuration and streaming order with hand-computed expectations.
module tb_sgbm_delay_pipe;

  localparam int unsigned DW = 864;
  localparam int unsigned MW = 10;
  localparam int unsigned PW = 5;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          cfg_wr;
  logic [PW-1:0] cfg_depth;
  logic [DW-1:0] data_in;
  logic [MW-1:0] row_in;
  logic [MW-1:0] col_in;
  logic          en;
  logic [DW-1:0] data_out;
  logic [MW-1:0] row_out;
  logic [MW-1:0] col_out;
  logic          valid;
  logic [PW-1:0] depth_cur;
  logic [PW-1:0] occ;

  int n_cmp;
  int n_err;

  logic [DW-1:0] ones;
  logic [DW-1:0] pat_a5;
  logic [DW-1:0] pat_3c;

  sgbm_delay_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .cfg_wr    (cfg_wr),
    .cfg_depth (cfg_depth),
    .data_in   (data_in),
    .row_in    (row_in),
    .col_in    (col_in),
    .en        (en),
    .data_out  (data_out),
    .row_out   (row_out),
    .col_out   (col_out),
    .valid     (valid),
    .depth_cur (depth_cur),
    .occ       (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    ones   = '1;
    pat_a5 = {108{8'hA5}};
    pat_3c = {108{8'h3C}};

    rst = 1'b1; stall = 1'b0; flush = 1'b0; cfg_wr = 1'b0; cfg_depth = '0;
    data_in = '0; row_in = '0; col_in = '0; en = 1'b0;

    // Reset held for two edges.
    step();
    step();
    check("rst_valid", DW'(valid), DW'(0));
    check("rst_occ", DW'(occ), DW'(0));
    check("rst_depth", DW'(depth_cur), DW'(13));
    check("rst_data", data_out, ones);
    check("rst_row", DW'(row_out), DW'(0));
    check("rst_col", DW'(col_out), DW'(0));
    rst = 1'b0;

    // Latency at depth 13: the capture edge is the first of 13 edges.
    data_in = pat_a5; row_in = 10'd7; col_in = 10'd9; en = 1'b1;
    step();
    data_in = '0; row_in = '0; col_in = '0; en = 1'b0;
    check("lat_occ_cap", DW'(occ), DW'(1));
    check("lat_v_cap", DW'(valid), DW'(0));
    for (int k = 2; k <= 12; k++) begin
      step();
      check("lat_v_flight", DW'(valid), DW'(0));
      check("lat_occ_flight", DW'(occ), DW'(1));
    end
    step();
    check("lat_v_out", DW'(valid), DW'(1));
    check("lat_data", data_out, pat_a5);
    check("lat_row", DW'(row_out), DW'(7));
    check("lat_col", DW'(col_out), DW'(9));
    check("lat_occ_out", DW'(occ), DW'(1));
    step();
    check("lat_v_after", DW'(valid), DW'(0));
    check("lat_occ_after", DW'(occ), DW'(0));

    // Stall for 3 cycles mid-flight; en pulses while stalled are dropped.
    data_in = pat_3c; row_in = 10'd3; col_in = 10'd4; en = 1'b1;
    step();
    data_in = '0; row_in = '0; col_in = '0; en = 1'b0;
    for (int k = 0; k < 4; k++) step();
    stall = 1'b1; en = 1'b1; data_in = ones; row_in = 10'd1; col_in = 10'd1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stl_occ_hold", DW'(occ), DW'(1));
      check("stl_v_hold", DW'(valid), DW'(0));
    end
    stall = 1'b0; en = 1'b0; data_in = '0; row_in = '0; col_in = '0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("stl_v_flight", DW'(valid), DW'(0));
    end
    step();
    check("stl_v_out", DW'(valid), DW'(1));
    check("stl_data", data_out, pat_3c);
    check("stl_row", DW'(row_out), DW'(3));
    check("stl_col", DW'(col_out), DW'(4));
    for (int k = 0; k < 5; k++) begin
      step();
      check("stl_v_none", DW'(valid), DW'(0));
      check("stl_occ_none", DW'(occ), DW'(0));
    end

    // Flush while stalled with 5 samples in flight.
    en = 1'b1; data_in = pat_a5;
    for (int k = 0; k < 5; k++) step();
    check("fl_occ_pre", DW'(occ), DW'(5));
    stall = 1'b1; flush = 1'b1;
    step();
    check("fl_occ", DW'(occ), DW'(0));
    check("fl_v", DW'(valid), DW'(0));
    stall = 1'b0; flush = 1'b0; en = 1'b0; data_in = '0;
    for (int k = 0; k < 16; k++) begin
      step();
      check("fl_v_after", DW'(valid), DW'(0));
    end
    check("fl_occ_after", DW'(occ), DW'(0));

    // Depth 4, with an in-flight sample discarded by the cfg write.
    en = 1'b1; row_in = 10'd2;
    step();
    en = 1'b0; row_in = '0;
    check("cfg_occ_pre", DW'(occ), DW'(1));
    cfg_wr = 1'b1; cfg_depth = 5'd4;
    step();
    cfg_wr = 1'b0;
    check("cfg4_depth", DW'(depth_cur), DW'(4));
    check("cfg4_occ", DW'(occ), DW'(0));
    en = 1'b1; row_in = 10'd11;
    step();
    en = 1'b0; row_in = '0;
    check("cfg4_v_cap", DW'(valid), DW'(0));
    for (int k = 0; k < 2; k++) begin
      step();
      check("cfg4_v_flight", DW'(valid), DW'(0));
    end
    step();
    check("cfg4_v_out", DW'(valid), DW'(1));
    check("cfg4_row", DW'(row_out), DW'(11));
    step();
    check("cfg4_v_after", DW'(valid), DW'(0));
    check("cfg4_occ_after", DW'(occ), DW'(0));

    // Depth 0 clamps to 1.
    cfg_wr = 1'b1; cfg_depth = 5'd0;
    step();
    cfg_wr = 1'b0;
    check("cfg0_depth", DW'(depth_cur), DW'(1));
    en = 1'b1; col_in = 10'd5;
    step();
    en = 1'b0; col_in = '0;
    check("cfg1_v_out", DW'(valid), DW'(1));
    check("cfg1_col", DW'(col_out), DW'(5));
    check("cfg1_occ", DW'(occ), DW'(1));
    step();
    check("cfg1_v_after", DW'(valid), DW'(0));
    check("cfg1_occ_after", DW'(occ), DW'(0));

    // Depth 20 clamps to 16.
    cfg_wr = 1'b1; cfg_depth = 5'd20;
    step();
    cfg_wr = 1'b0;
    check("cfg20_depth", DW'(depth_cur), DW'(16));

    // Stream of 20 samples at depth 16, reset once output col 10 is showing.
    for (int i = 0; i < 26; i++) begin
      en = (i < 20);
      col_in = MW'(i);
      step();
      check("str_occ", DW'(occ), DW'((i < 20) ? ((i + 1 < 16) ? i + 1 : 16) : 35 - i));
      check("str_v", DW'(valid), DW'(i >= 15));
      if (i >= 15) check("str_col", DW'(col_out), DW'(i - 15));
    end
    en = 1'b0; col_in = '0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("str_rst_v", DW'(valid), DW'(0));
    check("str_rst_occ", DW'(occ), DW'(0));
    check("str_rst_depth", DW'(depth_cur), DW'(13));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
